// File: rtl/mdu_seq_if.sv
// Request, result and shared-ALU signals between the multicycle control path and mdu_seq.
// master is the control FSM plus the ALU it owns; slave is the sequencer.
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div_by_zero;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_cout;

    modport master (
        output start, op, rs, rt, alu_result, alu_cout,
        input  busy, done, hi, lo, div_by_zero, alu_a, alu_b, alu_op
    );

    modport slave (
        input  start, op, rs, rt, alu_result, alu_cout,
        output busy, done, hi, lo, div_by_zero, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that borrows the core's shared ALU while busy.
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up for signed ops.
module mdu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic      clk,
    input  logic      reset,
    mdu_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_FIX_LO,
        S_FIX_HI,
        S_DONE
    } state_t;

    localparam logic [3:0]       ALU_ADD  = 4'b0000;
    localparam logic [3:0]       ALU_SUB  = 4'b0001;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t          state;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] b_q;
    logic [CNT_W-1:0] cnt;
    logic            is_div;
    logic            is_signed;
    logic            sign_a;
    logic            sign_b;
    logic            borrow;
    logic            dbz_q;
    logic            busy_q;
    logic            done_q;

    logic [XLEN-1:0] rem_shift;
    logic            neg_result;
    logic            neg_hi;
    logic [XLEN-1:0] alu_a_c;
    logic [XLEN-1:0] alu_b_c;
    logic [3:0]      alu_op_c;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign rem_shift  = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign neg_result = sign_a ^ sign_b;
    assign neg_hi     = is_div ? sign_a : neg_result;

    // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_op_c = ALU_ADD;
        alu_a_c  = '0;
        alu_b_c  = '0;
        case (state)
            S_NEG_A: begin
                alu_op_c = ALU_SUB;
                alu_b_c  = lo_q;
            end
            S_NEG_B: begin
                alu_op_c = ALU_SUB;
                alu_b_c  = b_q;
            end
            S_ITER: begin
                alu_op_c = is_div ? ALU_SUB : ALU_ADD;
                alu_a_c  = is_div ? rem_shift : hi_q;
                alu_b_c  = b_q;
            end
            S_FIX_LO: begin
                alu_op_c = ALU_SUB;
                alu_b_c  = lo_q;
            end
            S_FIX_HI: begin
                if (is_div) begin
                    alu_op_c = ALU_SUB;
                    alu_b_c  = hi_q;
                end else begin
                    alu_op_c = ALU_ADD;
                    alu_a_c  = ~hi_q;
                    alu_b_c  = {{(XLEN-1){1'b0}}, ~borrow};
                end
            end
            default: begin
                alu_op_c = ALU_ADD;
                alu_a_c  = '0;
                alu_b_c  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            borrow    <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        is_div    <= bus.op[1];
                        is_signed <= bus.op[0];
                        sign_a    <= bus.op[0] & bus.rs[XLEN-1];
                        sign_b    <= bus.op[0] & bus.rt[XLEN-1];
                        cnt       <= '0;
                        busy_q    <= 1'b1;
                        if (bus.op[1] && (bus.rt == '0)) begin
                            hi_q   <= bus.rs;
                            lo_q   <= '1;
                            b_q    <= bus.rt;
                            dbz_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            hi_q  <= '0;
                            lo_q  <= bus.rs;
                            b_q   <= bus.rt;
                            dbz_q <= 1'b0;
                            state <= bus.op[0] ? S_NEG_A : S_ITER;
                        end
                    end
                end
                S_NEG_A: begin
                    if (sign_a) lo_q <= bus.alu_result;
                    state <= S_NEG_B;
                end
                S_NEG_B: begin
                    if (sign_b) b_q <= bus.alu_result;
                    state <= S_ITER;
                end
                S_ITER: begin
                    if (is_div) begin
                        // A set hi[31] means the shifted remainder exceeds any 32-bit divisor.
                        if (hi_q[XLEN-1] || !bus.alu_cout) begin
                            hi_q <= bus.alu_result;
                            lo_q <= {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_q <= rem_shift;
                            lo_q <= {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else if (lo_q[0]) begin
                        hi_q <= {bus.alu_cout, bus.alu_result[XLEN-1:1]};
                        lo_q <= {bus.alu_result[0], lo_q[XLEN-1:1]};
                    end else begin
                        hi_q <= {1'b0, hi_q[XLEN-1:1]};
                        lo_q <= {hi_q[0], lo_q[XLEN-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        if (is_signed) begin
                            state <= S_FIX_LO;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_FIX_LO: begin
                    // Borrow from 0-lo tells FIX_HI whether the 64-bit negate carries into hi.
                    if (neg_result) lo_q <= bus.alu_result;
                    borrow <= bus.alu_cout;
                    state  <= S_FIX_HI;
                end
                S_FIX_HI: begin
                    if (neg_hi) hi_q <= bus.alu_result;
                    done_q <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.alu_a       = alu_a_c;
    assign bus.alu_b       = alu_b_c;
    assign bus.alu_op      = alu_op_c;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: a behavioural ALU, a 64-bit reference model feeding a
// scoreboard queue, and one task per feature comparing results, latency and control behaviour.
module tb_mdu_seq;

    localparam int         XLEN     = 32;
    localparam int         MAX_WAIT = 100;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t scoreboard[$];
    logic [XLEN:0] alu_full;

    mdu_seq_if #(.XLEN(XLEN)) bus();

    mdu_seq #(.XLEN(XLEN), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Shared ALU: ADD carries out, SUB raises cout on borrow.
    always_comb begin
        alu_full = '0;
        case (bus.alu_op)
            ALU_ADD: alu_full = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            ALU_SUB: alu_full = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            default: alu_full = '0;
        endcase
    end
    assign bus.alu_result = alu_full[XLEN-1:0];
    assign bus.alu_cout   = alu_full[XLEN];

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        p     = '0;
        e.dbz = 1'b0;
        e.lat = op[0] ? 37 : 33;
        if (op[1] && b == 32'd0) begin
            p     = {a, 32'hFFFF_FFFF};
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            case (op)
                2'b00:   p = {32'd0, a} * {32'd0, b};
                2'b01:   p = sa * sbv;
                2'b10:   p = {a % b, a / b};
                default: begin
                    q = sa / sbv;
                    r = sa % sbv;
                    p = {r[31:0], q[31:0]};
                end
            endcase
        end
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    // Called in the low clock phase; start is sampled by the next rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        scoreboard.push_back(model(op, a, b));
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Counts cycles after the start edge until done; inj_cyc > 0 pulses a stray start then.
    task automatic wait_done(input int inj_cyc, output int lat, output int busy_cnt,
                             output bit alu_ok, output logic dbz1, output bit idle_ok);
        lat      = -1;
        busy_cnt = 0;
        alu_ok   = 1'b1;
        dbz1     = 1'bx;
        for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
            @(negedge clk);
            if (cyc == 1) dbz1 = bus.div_by_zero;
            if (cyc == inj_cyc) begin
                bus.start = 1'b1;
                bus.op    = 2'b10;
                bus.rs    = 32'h1234_5678;
                bus.rt    = 32'h0000_0003;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.alu_op !== ALU_ADD && bus.alu_op !== ALU_SUB) alu_ok = 1'b0;
            if (bus.done === 1'b1) begin
                if (bus.alu_op !== ALU_ADD || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) alu_ok = 1'b0;
                lat = cyc;
                break;
            end
        end
        @(negedge clk);
        idle_ok = (bus.busy === 1'b0) && (bus.done === 1'b0) && (bus.alu_op === ALU_ADD)
                  && (bus.alu_a === 32'd0) && (bus.alu_b === 32'd0);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.rs    = '0;
        bus.rt    = '0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000)
            $display("FAIL reset flags: got busy=%b done=%b dbz=%b, expected 0 0 0", bus.busy, bus.done, bus.div_by_zero);
        else n_pass++;
        n_total++;
        if ({bus.hi, bus.lo} !== 64'd0)
            $display("FAIL reset hilo: got hi=%h lo=%h, expected 0 0", bus.hi, bus.lo);
        else n_pass++;
        n_total++;
        if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 68'd0)
            $display("FAIL reset alu: got op=%h a=%h b=%h, expected ADD 0 0", bus.alu_op, bus.alu_a, bus.alu_b);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.busy !== 1'b0)
            $display("FAIL idle after reset: got busy=%b, expected 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_multiply();
        logic [1:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        int          lat, busy_cnt;
        bit          alu_ok, idle_ok;
        logic        dbz1;
        exp_t        e;
        ops = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd6, $urandom, $urandom};
        bs  = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd7, $urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(0, lat, busy_cnt, alu_ok, dbz1, idle_ok);
            e = scoreboard.pop_front();
            n_total++;
            if (lat !== e.lat) $display("FAIL mul[%0d] latency: got %0d, expected %0d", i, lat, e.lat);
            else n_pass++;
            n_total++;
            if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz})
                $display("FAIL mul[%0d] result: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                         i, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
            else n_pass++;
            n_total++;
            if (busy_cnt !== e.lat || !alu_ok || !idle_ok)
                $display("FAIL mul[%0d] control: got busy_cycles=%0d alu_ok=%0b idle_ok=%0b, expected %0d 1 1",
                         i, busy_cnt, alu_ok, idle_ok, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_divide();
        logic [1:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] bs  [6];
        int          lat, busy_cnt;
        bit          alu_ok, idle_ok;
        logic        dbz1;
        exp_t        e;
        ops = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
        as  = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, $urandom, $urandom};
        bs  = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                ($urandom >> $urandom_range(0, 28)) | 32'd1, ($urandom >> $urandom_range(0, 28)) | 32'd1};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(0, lat, busy_cnt, alu_ok, dbz1, idle_ok);
            e = scoreboard.pop_front();
            n_total++;
            if (lat !== e.lat) $display("FAIL div[%0d] latency: got %0d, expected %0d", i, lat, e.lat);
            else n_pass++;
            n_total++;
            if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz})
                $display("FAIL div[%0d] result: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                         i, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
            else n_pass++;
            n_total++;
            if (!alu_ok || !idle_ok)
                $display("FAIL div[%0d] control: got alu_ok=%0b idle_ok=%0b, expected 1 1", i, alu_ok, idle_ok);
            else n_pass++;
        end
    endtask

    task automatic test_div_by_zero();
        logic [1:0]  ops [3];
        logic [31:0] as  [3];
        logic [31:0] bs  [3];
        int          lat, busy_cnt;
        bit          alu_ok, idle_ok;
        logic        dbz1;
        exp_t        e;
        ops = '{2'b10, 2'b11, 2'b10};
        as  = '{32'd100, 32'hFFFF_FFFB, 32'd100};
        bs  = '{32'd0, 32'd0, 32'd7};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(0, lat, busy_cnt, alu_ok, dbz1, idle_ok);
            e = scoreboard.pop_front();
            n_total++;
            if (lat !== e.lat) $display("FAIL dbz[%0d] latency: got %0d, expected %0d", i, lat, e.lat);
            else n_pass++;
            n_total++;
            if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz})
                $display("FAIL dbz[%0d] result: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                         i, bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
            else n_pass++;
            n_total++;
            if (dbz1 !== e.dbz) $display("FAIL dbz[%0d] flag after start: got %b, expected %b", i, dbz1, e.dbz);
            else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        int   lat, busy_cnt;
        bit   alu_ok, idle_ok;
        logic dbz1;
        exp_t e;
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(10, lat, busy_cnt, alu_ok, dbz1, idle_ok);
        e = scoreboard.pop_front();
        n_total++;
        if (lat !== e.lat || busy_cnt !== e.lat)
            $display("FAIL stray start timing: got latency=%0d busy_cycles=%0d, expected %0d %0d", lat, busy_cnt, e.lat, e.lat);
        else n_pass++;
        n_total++;
        if ({bus.hi, bus.lo} !== {e.hi, e.lo})
            $display("FAIL stray start result: got hi=%h lo=%h, expected hi=%h lo=%h", bus.hi, bus.lo, e.hi, e.lo);
        else n_pass++;
        n_total++;
        if (!alu_ok || !idle_ok)
            $display("FAIL stray start alu: got alu_ok=%0b idle_ok=%0b, expected 1 1", alu_ok, idle_ok);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   lat, busy_cnt;
        bit   alu_ok, idle_ok;
        logic dbz1;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(2'($urandom_range(0, 3)), $urandom, $urandom | 32'd1);
            wait_done(0, lat, busy_cnt, alu_ok, dbz1, idle_ok);
            e = scoreboard.pop_front();
            n_total++;
            if (lat !== e.lat || {bus.hi, bus.lo} !== {e.hi, e.lo})
                $display("FAIL b2b[%0d]: got latency=%0d hi=%h lo=%h, expected latency=%0d hi=%h lo=%h",
                         i, lat, bus.hi, bus.lo, e.lat, e.hi, e.lo);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int   done_seen = 0;
        logic busy_before;
        int   lat, busy_cnt;
        bit   alu_ok, idle_ok;
        logic dbz1;
        exp_t e;
        issue(2'b11, 32'hFFFF_FF9C, 32'd7);
        void'(scoreboard.pop_back());
        for (int cyc = 1; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        busy_before = bus.busy;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++;
        if (busy_before !== 1'b1) $display("FAIL reset_mid busy before: got %b, expected 1", busy_before);
        else n_pass++;
        n_total++;
        if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'd0)
            $display("FAIL reset_mid clear: got busy=%b done=%b hi=%h lo=%h, expected all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        n_total++;
        if (done_seen !== 0) $display("FAIL reset_mid done pulses: got %0d, expected 0", done_seen);
        else n_pass++;
        issue(2'b00, 32'd6, 32'd7);
        wait_done(0, lat, busy_cnt, alu_ok, dbz1, idle_ok);
        e = scoreboard.pop_front();
        n_total++;
        if (lat !== e.lat || {bus.hi, bus.lo} !== {e.hi, e.lo})
            $display("FAIL reset_mid recovery: got latency=%0d hi=%h lo=%h, expected latency=%0d hi=%h lo=%h",
                     lat, bus.hi, bus.lo, e.lat, e.hi, e.lo);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Iterative multiply/divide sequencer for the multicycle MIPS core. It implements MULT, MULTU, DIV and DIVU by driving the shared ALU through its operand and opcode ports: ADD = 4'b0000, SUB = 4'b0001. Results go into internal HI/LO registers. The control FSM issues start and waits for done; the ALU mux gives this block ownership while busy is high.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (XLEN-1 fits)

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
start  in  1  request pulse; sampled only in IDLE
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
rs  in  32  multiplicand/dividend, sampled with start
rt  in  32  multiplier/divisor, sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE state
hi  out  32  HI register (product[63:32] / remainder)
lo  out  32  LO register (product[31:0] / quotient)
div_by_zero  out  1  high with done when a divide had rt==0; cleared on next accepted start
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_op  out  4  ALU opcode, ADD or SUB only
alu_result  in  32  ALU result (combinational)
alu_cout  in  1  ALU carry/borrow out

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
- ALU outputs in IDLE and DONE: alu_op=ADD, alu_a=0, alu_b=0.
- Start acceptance: start is accepted in IDLE only. Latch rs, rt, op and the sign flags; clear div_by_zero. start while busy is ignored with no side effect.
- Divide by zero: a DIV/DIVU with rt==0 goes IDLE->DONE and sets hi=rs, lo=32'hFFFF_FFFF, div_by_zero=1.
- NEG_A (signed ops only): alu SUB 0-rs when rs[31]=1, else pass rs. Store the magnitude.
- NEG_B (signed ops only): same operation on rt.
- ITER (exactly 32 cycles, counter 0..31): per-iteration update depends on op.
- Multiply, per iteration: hi starts at 0, lo=|rs|, mcand=|rt|.
  - If lo[0]=1: alu ADD hi+mcand, then hi={alu_cout, alu_result[31:1]}, lo={alu_result[0], lo[31:1]}.
  - Else: hi={0, hi[31:1]}, lo={hi[0], lo[31:1]}.
- Divide, per iteration (restoring): hi (rem) starts at 0, lo=|rs|, div=|rt|.
  - alu_a={hi[30:0], lo[31]}, alu_b=div, SUB.
  - If hi[31]=1 or alu_cout=0 (no borrow): hi=alu_result, lo={lo[30:0],1}.
  - Else: hi=alu_a, lo={lo[30:0],0}.
- FIX_LO (signed ops only):
  - MULT with a negative product: alu SUB 0-lo and capture borrow=alu_cout.
  - DIV with quotient sign negative (rs[31]^rt[31]): lo=0-lo.
  - Otherwise hold.
- FIX_HI (signed ops only):
  - MULT with a negative product: alu ADD ~hi + !borrow.
  - DIV with rs[31]=1: hi=0-hi (remainder takes the dividend sign).
  - Otherwise hold.
- DONE: done=1 for exactly one cycle, then IDLE. hi/lo hold until the next accepted start.
- Latency, counted from the edge sampling start to the cycle with done high:
  - unsigned: 33 cycles (32 ITER + DONE)
  - signed: 37 cycles (NEG_A, NEG_B, 32 ITER, FIX_LO, FIX_HI, DONE)
  - divide by zero: 1 cycle
  - Latency is data-independent.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0, no flag.
- Reset mid-operation: immediate IDLE, hi/lo cleared, no done pulse.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT rs=-3, rt=7 -> done at cycle 37; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000×0x80000000 -> hi=0x40000000, lo=0.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=7 -> lo=14, hi=2 at cycle 33. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 -> done 1 cycle after start; div_by_zero=1, hi=100, lo=0xFFFFFFFF. The next start clears div_by_zero.
- Pulse start with different operands at cycle 10 of a MULTU -> ignored; original result and latency unchanged; alu_op only ever ADD/SUB while busy and ADD with zero operands when idle.
- Assert reset at cycle 20 of a DIV -> busy=0, hi=lo=0 immediately, no done. A fresh MULTU 6×7 afterwards -> lo=42, hi=0.
